// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D cache memory-port arbiter: one-hot FSM state
// codes and the grant-side encoding used by the picker and the top.
package cache_mem_arbiter_pkg;

    // One-hot arbiter states
    typedef enum logic [4:0] {
        ARB_IDLE    = 5'b00001,
        ARB_GRANT_I = 5'b00010,
        ARB_GRANT_D = 5'b00100,
        ARB_DONE_I  = 5'b01000,
        ARB_DONE_D  = 5'b10000
    } arb_state_e;

    // Which cache owns (or last owned) the memory port
    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_e;

    // True in either grant state, i.e. while the memory request is live
    function automatic logic arb_in_grant(input arb_state_e s);
        return (s == ARB_GRANT_I) || (s == ARB_GRANT_D);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone requester wins outright; on a tie the
// side that did not win last time is chosen. Purely combinational.
module cache_mem_arbiter_rr_pick
    import cache_mem_arbiter_pkg::*;
(
    input  logic i_req_icache,
    input  logic i_req_dcache,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    // Select the winner from the two request levels and the previous owner
    always_comb begin
        o_valid = i_req_icache | i_req_dcache;
        o_grant = SIDE_I;
        if (i_req_icache && i_req_dcache) begin
            o_grant = (i_last_grant == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (i_req_dcache) begin
            o_grant = SIDE_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single refill/write-back memory port between the I-cache and
// the D-cache, one transaction at a time, round-robin on ties.
// Optional feature: define ARB_TIMEOUT_EN to add a grant watchdog that
// forces completion (with err and zeroed read data) after TMO_W-bit overflow.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; requests sampled and picked here
// GRANT_I | mem_ena high for the I-cache refill, waiting for mem_ok
// GRANT_D | mem_ena high for the D-cache refill/write-back
// DONE_I  | i_ok pulse; requests ignored so the I-cache can drop its level
// DONE_D  | d_ok pulse; same for the D-cache
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int TMO_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_ena,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ok,
    input  logic                d_req_ena,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ok,
    output logic                mem_ena,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ok,
    output logic                err
);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic                r_last_grant;
    logic                w_pick_valid;
    logic                w_pick_grant;
    logic                w_grant_ev;
    logic                w_in_grant;
    logic                w_timeout;

    logic                r_mem_ena;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W/8-1:0] r_mem_wstrb;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_i_ok;
    logic                r_d_ok;

    cache_mem_arbiter_rr_pick u_rr_pick (
        .i_req_icache (i_req_ena),
        .i_req_dcache (d_req_ena),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_grant      (w_pick_grant)
    );

    assign w_grant_ev = (r_state == ARB_IDLE) && w_pick_valid;
    assign w_in_grant = arb_in_grant(r_state);

`ifdef ARB_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Watchdog: restart on every grant, count grant cycles without mem_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_grant_ev) begin
            r_tmo_cnt <= '0;
        end else if (w_in_grant && !mem_ok) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // mem_ok in the same cycle as overflow takes priority over the timeout
    assign w_timeout = w_in_grant && !mem_ok && (r_tmo_cnt == '1);

    // One-cycle error flag, aligned with the forced x_ok pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; DONE states always fall back to IDLE unconditionally
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = (w_pick_grant == SIDE_D) ? ARB_GRANT_D : ARB_GRANT_I;
                end
            end
            ARB_GRANT_I: begin
                if (mem_ok || w_timeout) begin
                    w_next_state = ARB_DONE_I;
                end
            end
            ARB_GRANT_D: begin
                if (mem_ok || w_timeout) begin
                    w_next_state = ARB_DONE_D;
                end
            end
            ARB_DONE_I: w_next_state = ARB_IDLE;
            ARB_DONE_D: w_next_state = ARB_IDLE;
            default:    w_next_state = ARB_IDLE;
        endcase
    end

    // Handshake outputs registered from the next state so none is combinational
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_ena <= 1'b0;
            r_i_ok    <= 1'b0;
            r_d_ok    <= 1'b0;
        end else begin
            r_mem_ena <= arb_in_grant(w_next_state);
            r_i_ok    <= (w_next_state == ARB_DONE_I);
            r_d_ok    <= (w_next_state == ARB_DONE_D);
        end
    end

    // Latch the winner's request fields once, at the grant edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= SIDE_I;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
        end else if (w_grant_ev) begin
            r_last_grant <= w_pick_grant;
            if (w_pick_grant == SIDE_D) begin
                r_mem_we    <= d_req_we;
                r_mem_addr  <= d_req_addr;
                r_mem_wdata <= d_wdata;
                r_mem_wstrb <= d_wstrb;
            end else begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_req_addr;
                r_mem_wdata <= '0;
                r_mem_wstrb <= '0;
            end
        end
    end

    // Return data per side; it holds until that side's next completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (r_state == ARB_GRANT_I) begin
                if (mem_ok) begin
                    r_i_rdata <= mem_rdata;
                end else if (w_timeout) begin
                    r_i_rdata <= '0;
                end
            end
            if (r_state == ARB_GRANT_D) begin
                if (mem_ok) begin
                    if (!r_mem_we) begin
                        r_d_rdata <= mem_rdata;
                    end
                end else if (w_timeout) begin
                    r_d_rdata <= '0;
                end
            end
        end
    end

    assign mem_ena   = r_mem_ena;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_ok      = r_i_ok;
    assign d_ok      = r_d_ok;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: table of request scenarios,
// a scoreboard queue of expected grants, plus reset and stray mem_ok sequences.
module tb_cache_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          i_req_ena;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ok;
    logic          d_req_ena;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_wdata;
    logic [7:0]    d_wstrb;
    logic [DW-1:0] d_rdata;
    logic          d_ok;
    logic          mem_ena;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          mem_ok;
    logic          err;

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_ena  (i_req_ena),
        .i_req_addr (i_req_addr),
        .i_rdata    (i_rdata),
        .i_ok       (i_ok),
        .d_req_ena  (d_req_ena),
        .d_req_we   (d_req_we),
        .d_req_addr (d_req_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_rdata    (d_rdata),
        .d_ok       (d_ok),
        .mem_ena    (mem_ena),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ok     (mem_ok),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          i_req;
        logic          d_req;
        logic          hold;
        int            n_txn;
        logic          first_d;
        logic [AW-1:0] i_addr;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic [7:0]    d_wstrb;
        int            lat;
        logic [DW-1:0] rbase;
    } vec_t;

    typedef struct {
        logic          side_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [7:0]    wstrb;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    vec_t          vecs[6];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] m_i_rdata = '0;
    logic [DW-1:0] m_d_rdata = '0;
    logic          m_last_d  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic act_i;
        logic act_d;
        exp_t e;
        int   k;
        int   n;
        act_i = v.i_req;
        act_d = v.d_req;
        // Reference order: lone requester wins, ties go opposite the last winner
        for (int t = 0; t < v.n_txn; t++) begin
            logic pick_d;
            pick_d   = (act_i && act_d) ? !m_last_d : act_d;
            m_last_d = pick_d;
            e.side_d = pick_d;
            e.we     = pick_d ? v.d_we : 1'b0;
            e.addr   = pick_d ? v.d_addr : v.i_addr;
            e.wdata  = pick_d ? v.d_wdata : '0;
            e.wstrb  = pick_d ? v.d_wstrb : 8'h00;
            e.rdata  = v.rbase + 64'(t * 256);
            exp_q.push_back(e);
            if (!v.hold) begin
                if (pick_d) act_d = 1'b0;
                else        act_i = 1'b0;
            end
        end
        i_req_ena  = v.i_req;
        i_req_addr = v.i_addr;
        d_req_ena  = v.d_req;
        d_req_we   = v.d_we;
        d_req_addr = v.d_addr;
        d_wdata    = v.d_wdata;
        d_wstrb    = v.d_wstrb;
        k = 0;
        while (exp_q.size() > 0) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mem_ena && n < 50);
            if (!mem_ena) begin
                checks++;
                errors++;
                $display("FAIL v%0d grant_wait: mem_ena never rose", idx);
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            check($sformatf("v%0d.%0d grant_latency", idx, k), 64'(n), 64'd1);
            check($sformatf("v%0d.%0d mem_we", idx, k), 64'(mem_we), 64'(e.we));
            check($sformatf("v%0d.%0d mem_addr", idx, k), mem_addr, e.addr);
            check($sformatf("v%0d.%0d mem_wdata", idx, k), mem_wdata, e.wdata);
            check($sformatf("v%0d.%0d mem_wstrb", idx, k), 64'(mem_wstrb), 64'(e.wstrb));
            // Requester-side inputs may wander while granted; latched fields must not
            d_req_addr = ~v.d_addr;
            i_req_addr = ~v.i_addr;
            repeat (v.lat) @(negedge clk);
            check($sformatf("v%0d.%0d mem_ena_held", idx, k), 64'(mem_ena), 64'd1);
            check($sformatf("v%0d.%0d mem_addr_stable", idx, k), mem_addr, e.addr);
            d_req_addr = v.d_addr;
            i_req_addr = v.i_addr;
            mem_ok    = 1'b1;
            mem_rdata = e.rdata;
            @(negedge clk);
            mem_ok    = 1'b0;
            mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            if (e.side_d && !e.we) m_d_rdata = e.rdata;
            if (!e.side_d)         m_i_rdata = e.rdata;
            check($sformatf("v%0d.%0d i_ok", idx, k), 64'(i_ok), 64'(!e.side_d));
            check($sformatf("v%0d.%0d d_ok", idx, k), 64'(d_ok), 64'(e.side_d));
            check($sformatf("v%0d.%0d mem_ena_drop", idx, k), 64'(mem_ena), 64'd0);
            check($sformatf("v%0d.%0d i_rdata", idx, k), i_rdata, m_i_rdata);
            check($sformatf("v%0d.%0d d_rdata", idx, k), d_rdata, m_d_rdata);
            check($sformatf("v%0d.%0d err", idx, k), 64'(err), 64'd0);
            if (k == 0) check($sformatf("v%0d first_grant_d", idx), 64'(d_ok), 64'(v.first_d));
            if (!v.hold || exp_q.size() == 0) begin
                if (e.side_d) d_req_ena = 1'b0;
                else          i_req_ena = 1'b0;
                if (exp_q.size() == 0) begin
                    i_req_ena = 1'b0;
                    d_req_ena = 1'b0;
                end
            end
            @(negedge clk);
            check($sformatf("v%0d.%0d ok_single", idx, k), 64'({i_ok, d_ok}), 64'd0);
            check($sformatf("v%0d.%0d idle_gap", idx, k), 64'(mem_ena), 64'd0);
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{i_req:1'b1, d_req:1'b0, hold:1'b0, n_txn:1, first_d:1'b0,
                    i_addr:64'h8000_0040, d_we:1'b0, d_addr:64'h0, d_wdata:64'h0,
                    d_wstrb:8'h00, lat:4, rbase:64'h13};
        vecs[1] = '{i_req:1'b1, d_req:1'b1, hold:1'b0, n_txn:2, first_d:1'b1,
                    i_addr:64'h8000_0080, d_we:1'b0, d_addr:64'h8000_2000, d_wdata:64'h0,
                    d_wstrb:8'h00, lat:2, rbase:64'h1111_0000_0000_0000};
        vecs[2] = '{i_req:1'b1, d_req:1'b1, hold:1'b1, n_txn:6, first_d:1'b1,
                    i_addr:64'h8000_0100, d_we:1'b0, d_addr:64'h8000_0200, d_wdata:64'h0,
                    d_wstrb:8'h00, lat:0, rbase:64'h2200};
        vecs[3] = '{i_req:1'b0, d_req:1'b1, hold:1'b0, n_txn:1, first_d:1'b1,
                    i_addr:64'h0, d_we:1'b1, d_addr:64'h8000_1000, d_wdata:64'hDEAD_BEEF_0000_0001,
                    d_wstrb:8'hFF, lat:3, rbase:64'h5555};
        vecs[4] = '{i_req:1'b1, d_req:1'b1, hold:1'b0, n_txn:2, first_d:1'b1,
                    i_addr:64'h8000_0300, d_we:1'b1, d_addr:64'h8000_3008, d_wdata:64'h0123_4567_89AB_CDEF,
                    d_wstrb:8'h0F, lat:1, rbase:64'h7700};
        vecs[5] = '{i_req:1'b1, d_req:1'b0, hold:1'b0, n_txn:1, first_d:1'b0,
                    i_addr:64'h8000_0400, d_we:1'b0, d_addr:64'h0, d_wdata:64'h0,
                    d_wstrb:8'h00, lat:0, rbase:64'hCAFE};

        rst        = 1'b1;
        i_req_ena  = 1'b0;
        i_req_addr = '0;
        d_req_ena  = 1'b0;
        d_req_we   = 1'b0;
        d_req_addr = '0;
        d_wdata    = '0;
        d_wstrb    = '0;
        mem_rdata  = '0;
        mem_ok     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst mem_ena", 64'(mem_ena), 64'd0);
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst mem_addr", mem_addr, 64'd0);
        check("rst mem_wdata", mem_wdata, 64'd0);
        check("rst mem_wstrb", 64'(mem_wstrb), 64'd0);
        check("rst rdata", i_rdata | d_rdata, 64'd0);
        check("rst ok_err", 64'({i_ok, d_ok, err}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) run_vec(vecs[v], v);

        // Stray mem_ok while idle must be ignored
        mem_ok    = 1'b1;
        mem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        mem_ok = 1'b0;
        check("idle_memok ok", 64'({i_ok, d_ok}), 64'd0);
        check("idle_memok mem_ena", 64'(mem_ena), 64'd0);
        check("idle_memok i_rdata", i_rdata, m_i_rdata);
        check("idle_memok d_rdata", d_rdata, m_d_rdata);
        @(negedge clk);
        check("idle_memok ok_after", 64'({i_ok, d_ok}), 64'd0);

        // Reset two cycles into a grant: request dropped asynchronously, no ok
        i_req_ena  = 1'b1;
        i_req_addr = 64'h8000_0500;
        @(negedge clk);
        check("midrst granted", 64'(mem_ena), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst mem_ena_async", 64'(mem_ena), 64'd0);
        check("midrst mem_addr_clear", mem_addr, 64'd0);
        i_req_ena = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        m_last_d  = 1'b0;
        m_i_rdata = '0;
        m_d_rdata = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("midrst quiet%0d", c), 64'({i_ok, d_ok, mem_ena}), 64'd0);
        end

        for (int v = 4; v < 6; v++) run_vec(vecs[v], v);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
